// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start, 5..NB_DATA_MAX data bits LSB first, optional parity, 1/2 stops.
// Start bit appears on the acceptance edge; o_ready is low for the whole frame, so requests stall until completion.
module uart_tx_cfg #(
    parameter int NB_DATA_MAX = 8,
    parameter int N_OVS       = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_tick,
    input  logic                   i_valid,
    input  logic [NB_DATA_MAX-1:0] i_din,
    input  logic [3:0]             i_nbits,
    input  logic [1:0]             i_parity,
    input  logic                   i_two_stop,
    output logic                   o_ready,
    output logic                   o_busy,
    output logic                   o_tx_done,
    output logic                   o_tx
);

    localparam int             CW        = (N_OVS > 1) ? $clog2(N_OVS) : 1;
    localparam logic [CW-1:0]  TICK_LAST = CW'(N_OVS - 1);
    localparam logic [3:0]     NB_MAX4   = 4'(NB_DATA_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          tick_cnt, tick_cnt_nxt;
    logic [3:0]             bit_idx, bit_idx_nxt;
    logic [3:0]             nbits_q, nbits_nxt;
    logic [NB_DATA_MAX-1:0] shreg, shreg_nxt;
    logic                   par_en_q, par_en_nxt;
    logic                   par_bit_q, par_bit_nxt;
    logic                   two_stop_q, two_stop_nxt;
    logic                   stop2_q, stop2_nxt;
    logic                   tx_q, tx_nxt;
    logic                   done_q, done_nxt;

    logic [3:0]             nbits_eff;
    logic                   par_calc;
    logic                   bit_end;

    // Parity is resolved at acceptance over the clamped width, so only valid bits contribute.
    always_comb begin
        nbits_eff = i_nbits;
        if ((i_nbits < 4'd5) || (i_nbits > NB_MAX4)) begin
            nbits_eff = NB_MAX4;
        end
        par_calc = 1'b0;
        for (int i = 0; i < NB_DATA_MAX; i++) begin
            if (4'(i) < nbits_eff) begin
                par_calc = par_calc ^ i_din[i];
            end
        end
    end

    assign bit_end = i_tick && (tick_cnt == TICK_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= S_IDLE;
            tick_cnt   <= '0;
            bit_idx    <= '0;
            nbits_q    <= '0;
            shreg      <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            stop2_q    <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            tick_cnt   <= tick_cnt_nxt;
            bit_idx    <= bit_idx_nxt;
            nbits_q    <= nbits_nxt;
            shreg      <= shreg_nxt;
            par_en_q   <= par_en_nxt;
            par_bit_q  <= par_bit_nxt;
            two_stop_q <= two_stop_nxt;
            stop2_q    <= stop2_nxt;
            tx_q       <= tx_nxt;
            done_q     <= done_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        tick_cnt_nxt = tick_cnt;
        bit_idx_nxt  = bit_idx;
        nbits_nxt    = nbits_q;
        shreg_nxt    = shreg;
        par_en_nxt   = par_en_q;
        par_bit_nxt  = par_bit_q;
        two_stop_nxt = two_stop_q;
        stop2_nxt    = stop2_q;
        tx_nxt       = tx_q;
        done_nxt     = 1'b0;

        if ((state != S_IDLE) && i_tick) begin
            tick_cnt_nxt = bit_end ? '0 : tick_cnt + CW'(1);
        end

        case (state)
            S_IDLE: begin
                if (i_valid) begin
                    state_nxt    = S_START;
                    tick_cnt_nxt = '0;
                    bit_idx_nxt  = '0;
                    nbits_nxt    = nbits_eff;
                    shreg_nxt    = i_din;
                    par_en_nxt   = (i_parity == 2'b01) || (i_parity == 2'b10);
                    par_bit_nxt  = (i_parity == 2'b10) ? ~par_calc : par_calc;
                    two_stop_nxt = i_two_stop;
                    stop2_nxt    = 1'b0;
                    tx_nxt       = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_nxt   = S_DATA;
                    tx_nxt      = shreg[0];
                    shreg_nxt   = shreg >> 1;
                    bit_idx_nxt = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx == (nbits_q - 4'd1)) begin
                        if (par_en_q) begin
                            state_nxt = S_PARITY;
                            tx_nxt    = par_bit_q;
                        end else begin
                            state_nxt = S_STOP;
                            tx_nxt    = 1'b1;
                            stop2_nxt = 1'b0;
                        end
                    end else begin
                        tx_nxt      = shreg[0];
                        shreg_nxt   = shreg >> 1;
                        bit_idx_nxt = bit_idx + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_nxt = S_STOP;
                    tx_nxt    = 1'b1;
                    stop2_nxt = 1'b0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (two_stop_q && !stop2_q) begin
                        stop2_nxt = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

    assign o_ready   = (state == S_IDLE);
    assign o_busy    = ~o_ready;
    assign o_tx_done = done_q;
    assign o_tx      = tx_q;

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Runtime-configurable UART transmitter, successor to the fixed 8N1 transmitter in the UART path. Data width (5..NB_DATA_MAX), parity (none/even/odd), stop bits (1/2) and oversampling ratio are selectable. Frames are accepted with a valid/ready handshake from the TX FIFO or interface controller and driven onto the serial line. Timing comes from the shared baud-rate tick generator.

Parameters:
NB_DATA_MAX, 8, maximum data bits per frame and width of i_din; legal range 5..9.
N_OVS, 16, i_tick pulses per serial bit (start, data, parity and stop alike); legal range 2..64.

Ports:
i_clk  in  1  system clock; all logic is on the rising edge.
i_reset  in  1  synchronous, active-high reset.
i_tick  in  1  baud oversampling strobe, one i_clk cycle wide.
i_valid  in  1  frame request; i_din and config are valid while high.
i_din  in  NB_DATA_MAX  payload, LSB transmitted first.
i_nbits  in  4  data bits per frame (5..NB_DATA_MAX).
i_parity  in  2  00 none, 01 even, 10 odd, 11 none.
i_two_stop  in  1  1 = two stop bits, 0 = one stop bit.
o_ready  out  1  high only in IDLE; the frame is accepted when i_valid && o_ready.
o_busy  out  1  high from acceptance until the frame completes.
o_tx_done  out  1  one-cycle pulse when the last stop bit completes.
o_tx  out  1  serial line; registered, idle high.

Behaviour:
- Reset (synchronous): state=IDLE, o_tx=1, o_ready=1, o_busy=0, o_tx_done=0, all counters and the shift register cleared. Reset mid-frame aborts the frame: o_tx=1 after the reset edge, no o_tx_done pulse.
- States: IDLE -> START -> DATA -> PARITY (skipped when parity is none) -> STOP -> IDLE.
- Acceptance edge:
  - Latch i_din, i_nbits, i_parity and i_two_stop.
  - Set o_tx=0 on this same edge, enter START and clear the tick counter.
  - Config or i_din changes after acceptance have no effect on the frame in flight.
- i_nbits outside 5..NB_DATA_MAX is clamped to NB_DATA_MAX. i_din bits above nbits are ignored.
- Bit timing:
  - The tick counter increments on i_tick and is ignored in IDLE.
  - An i_tick coinciding with the acceptance edge is not counted.
  - On the N_OVS-th counted tick of a bit: the counter resets to 0, the next bit value is registered onto o_tx, and the state or bit index advances.
  - o_tx changes only on these edges, so every bit spans exactly N_OVS ticks.
- DATA: shift the latched data right, sending bit 0 first; leave DATA after nbits bits.
- PARITY: even -> XOR of the nbits data bits; odd -> its inverse. Only the valid bits take part.
- STOP: o_tx=1 for N_OVS ticks, or 2*N_OVS ticks when two stop bits are selected.
- Frame completion, on the last stop tick:
  - state=IDLE, o_tx_done=1 for exactly one cycle, o_busy=0, o_ready=1 in that same cycle.
  - If i_valid is high in that cycle, the next frame is accepted, so back-to-back frames have no idle tick.
- Frame length in ticks = N_OVS*(1+nbits+P+S), where P = 0 or 1 and S = 1 or 2.
- o_busy = !o_ready at all times. o_tx_done never asserts outside the completion cycle.

Test Plan:
- 8N1, N_OVS=16, i_din=0xA5, ticks every 4 clocks: o_tx sequence 0,1,0,1,0,0,1,0,1,1, each held 16 ticks; o_tx_done pulses once after 160 ticks; o_ready=0 throughout the frame.
- 7E1, i_din=0x35 (four ones): data bits 1,0,1,0,1,1,0, then parity 0, then stop. Repeat with odd parity: parity bit 1. Total 160 ticks.
- 5 data bits, no parity, two stops, i_din=0xFF: bits 0,1,1,1,1,1,1,1; the stop level lasts 32 ticks; frame = 128 ticks; bits 7:5 do not appear on the line.
- i_nbits=3 and, separately, 12: both transmit 8 data bits (clamped); i_nbits changed mid-frame: the frame is unaffected.
- Assert i_reset for one cycle during data bit 4: o_tx=1 and o_ready=1 the next cycle, no o_tx_done pulse; a new 0x3C frame afterwards is correct.
- i_valid held high with 0x11 then 0x22: the second start bit begins on the edge after the first o_tx_done pulse, the gap between frames is under one tick, and both frames decode correctly.
